// File: rtl/iter_mul_acc_pkg.sv
// Shared definitions for the iterative HI/LO multiply-accumulate unit.
package iter_mul_acc_pkg;

  // FSM state encodings
  typedef enum logic [1:0] {
    MulFree = 2'b00,
    MulOn   = 2'b01,
    MulFix  = 2'b10,
    MulEnd  = 2'b11
  } mul_state_e;

  // Operation select; 2'b11 falls through to a plain multiply
  localparam logic [1:0] MulOpMul  = 2'b00;
  localparam logic [1:0] MulOpMadd = 2'b01;
  localparam logic [1:0] MulOpMsub = 2'b10;

  // Handshake levels shared with the other EX-stage long-latency units
  localparam logic MulStart          = 1'b1;
  localparam logic MulStop           = 1'b0;
  localparam logic MulResultReady    = 1'b1;
  localparam logic MulResultNotReady = 1'b0;

endpackage

// File: rtl/mul_pp_radix.sv
// Combinational partial-product generator: multiplicand x one RADIX_BITS digit.
module mul_pp_radix #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic [2*WIDTH-1:0]    mcand,
  input  logic [RADIX_BITS-1:0] digit,
  output logic [2*WIDTH-1:0]    pp
);

  // Shift-add over the digit bits; at most 4 terms for the legal radices
  always_comb begin
    pp = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (digit[i]) pp = pp + (mcand << i);
    end
  end

endmodule

// File: rtl/iter_mul_acc.sv
// Iterative shift-add multiplier with MADD/MSUB fusion and early termination.
// Operands are reduced to magnitudes at start; the sign is reapplied in MulFix.
module iter_mul_acc
  import iter_mul_acc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1,   // 1, 2 or 4; must divide WIDTH
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_mul_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int DW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(STEPS + 1);

  mul_state_e       state_q, state_d;
  logic [DW-1:0]    mcand_q, prod_q, acc_q, res_q;
  logic [DW-1:0]    pp, p_signed, res_d;
  logic [WIDTH-1:0] mplier_q, mplier_shr, mag1, mag2;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [1:0]       op_q;
  logic             neg_q, neg1, neg2;
  logic             accept, op_zero, last_step;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1)
  assign neg1 = signed_mul_i & opdata1_i[WIDTH-1];
  assign neg2 = signed_mul_i & opdata2_i[WIDTH-1];
  assign mag1 = neg1 ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign mag2 = neg2 ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

  assign accept  = (state_q == MulFree) && (start_i == MulStart) && !annul_i;
  assign op_zero = (opdata1_i == '0) || (opdata2_i == '0);

  assign mplier_shr = mplier_q >> RADIX_BITS;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign last_step  = (cnt_inc == CNT_W'(STEPS)) || (EARLY_TERM && (mplier_shr == '0));

  mul_pp_radix #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_pp (
    .mcand (mcand_q),
    .digit (mplier_q[RADIX_BITS-1:0]),
    .pp    (pp)
  );

  // Sign fix-up and accumulate; acc is the copy latched at start
  always_comb begin
    p_signed = neg_q ? (~prod_q + DW'(1)) : prod_q;
    case (op_q)
      MulOpMadd: res_d = acc_q + p_signed;
      MulOpMsub: res_d = acc_q - p_signed;
      default:   res_d = p_signed;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= MulFree;
    else      state_q <= state_d;
  end

  // Next-state logic; annul only matters while the operation is in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      MulFree: if (accept) state_d = op_zero ? MulFix : MulOn;
      MulOn: begin
        if (annul_i)        state_d = MulFree;
        else if (last_step) state_d = MulFix;
      end
      MulFix:  state_d = annul_i ? MulFree : MulEnd;
      MulEnd:  if (start_i == MulStop) state_d = MulFree;
      default: state_d = MulFree;
    endcase
  end

  // Outputs are a pure function of state so reset clears them immediately
  always_comb begin
    ready_o  = MulResultNotReady;
    result_o = '0;
    if (state_q == MulEnd) begin
      ready_o  = MulResultReady;
      result_o = res_q;
    end
  end

  // Datapath: latch at accept, iterate in MulOn, capture result in MulFix
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      op_q     <= MulOpMul;
      neg_q    <= 1'b0;
    end else begin
      case (state_q)
        MulFree: if (accept) begin
          op_q     <= op_i;
          acc_q    <= acc_i;
          neg_q    <= signed_mul_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          mcand_q  <= DW'(mag1);
          mplier_q <= mag2;
          prod_q   <= '0;
          cnt_q    <= '0;
        end
        MulOn: begin
          prod_q   <= prod_q + pp;
          mcand_q  <= mcand_q << RADIX_BITS;
          mplier_q <= mplier_shr;
          cnt_q    <= cnt_inc;
        end
        MulFix:  res_q <= res_d;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iter_mul_acc.md
# iter_mul_acc

Parametrised iterative shift-add multiplier with a fused multiply-accumulate option, radix selectable at elaboration, and early termination. It sits beside the EX stage as the HI/LO multiply unit and serves MULT/MULTU, MADD/MADDU and MSUB/MSUBU. It uses the same start/ready/annul handshake as the EX-stage long-latency units. Operands, accumulator and sign information are latched at start, so EX may change its inputs while the block is busy.

## Interface
- WIDTH, 32, operand width in bits; the result is 2*WIDTH bits.
- RADIX_BITS, 1, multiplier bits consumed per CALC cycle; legal values are 1, 2 and 4, and the value must divide WIDTH.
- EARLY_TERM, 1, when set, CALC ends as soon as the remaining multiplier bits are all zero.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  request a new operation; held high until the result has been consumed.
- annul_i  in  1  abort the operation in flight.
- signed_mul_i  in  1  1 selects signed operands, 0 selects unsigned.
- op_i  in  2  operation select: `MulOpMul`=00, `MulOpMadd`=01, `MulOpMsub`=10; 11 is treated as `MulOpMul`.
- opdata1_i  in  WIDTH  multiplicand.
- opdata2_i  in  WIDTH  multiplier.
- acc_i  in  2*WIDTH  accumulator input {HI,LO}; used only for MADD and MSUB.
- result_o  out  2*WIDTH  result; reset value 0.
- ready_o  out  1  result valid; reset value 0.

## Operation
- State machine has four states: `MulFree`, `MulOn`, `MulFix` and `MulEnd`.
- **MulFree**
  - result_o and ready_o are driven to 0.
  - If start_i=1 and annul_i=0, latch op_i, signed_mul_i, acc_i and the result sign. The sign is negative when signed_mul_i=1 and opdata1_i[MSB] differs from opdata2_i[MSB].
  - Latch magnitudes: in signed mode a negative operand is replaced by its two's complement, read as an unsigned WIDTH-bit value (the most-negative value gives magnitude 2^(WIDTH-1)).
  - Clear the product register and the counter.
  - If either operand is zero, go to MulFix with product 0; otherwise go to MulOn.
- **MulOn**, per cycle:
  - product += multiplicand * multiplier[RADIX_BITS-1:0].
  - multiplicand shifts left by RADIX_BITS; multiplier shifts right by RADIX_BITS; counter increments.
  - Go to MulFix when the counter reaches WIDTH/RADIX_BITS, or, with EARLY_TERM=1, when the shifted multiplier is zero.
- **MulFix**, one cycle:
  - If the sign is negative, p = ~product+1; otherwise p = product.
  - Compute result: MUL gives p; MADD gives acc+p; MSUB gives acc−p; all modulo 2^(2*WIDTH).
  - Register the result to result_o, set ready_o=1, go to MulEnd.
- **MulEnd**
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0, the next edge goes to MulFree, clears ready_o and sets result_o to 0.
- **Annul**
  - annul_i=1 in MulOn or MulFix forces MulFree on the next edge; ready_o never rises for that operation.
  - annul_i is ignored in MulEnd.
  - In MulFree, annul_i=1 blocks acceptance of a start.
- start_i falling during MulOn or MulFix does not abort; only annul_i aborts.
- Reset asserted at any time, including mid-MulOn, immediately forces MulFree with result_o=0 and ready_o=0.

## Timing
- E0 is the edge that accepts start.
- n is the number of MulOn cycles:
  - n = 0 for a zero operand.
  - With EARLY_TERM=1, n = ceil(bitlen(|opdata2|)/RADIX_BITS), where bitlen is the index of the top set bit plus one.
  - With EARLY_TERM=0, n = WIDTH/RADIX_BITS.
- ready_o rises at edge E0+n+1.
- Worst case: WIDTH=32, RADIX_BITS=1 gives 33 cycles; RADIX_BITS=4 gives 9 cycles.
- After start_i falls in MulEnd, the earliest next acceptance is 2 edges later: one edge to return to MulFree, then the acceptance edge.
- Inputs are sampled only at E0; acc_i is not re-read in MulFix.

## Structure
- The following belong in the shared defines header:
  - state encodings `MulFree`, `MulOn`, `MulFix`, `MulEnd`;
  - op codes `MulOpMul`, `MulOpMadd`, `MulOpMsub`;
  - `MulStart`, `MulStop`, `MulResultReady`, `MulResultNotReady`.
- Sub-module mul_pp_radix: a combinational partial-product generator, parametrised by WIDTH and RADIX_BITS, that computes multiplicand × digit over 2*WIDTH bits.
- Counter width is $clog2(WIDTH/RADIX_BITS+1).

## Test plan
- Unsigned MUL, RADIX_BITS=1, 0xFFFFFFFF×0xFFFFFFFF -> result_o=0xFFFFFFFE00000001, ready_o rises at E33.
- Signed MUL, 0xFFFFFFFD×0x00000005 -> 0xFFFFFFFFFFFFFFF1 at E4 (n=3).
  - Then hold start_i high for 5 cycles: ready_o and result_o remain stable.
  - Then drop start_i: ready_o=0 and result_o=0 one edge later.
- Signed MSUB, acc_i=0x64, 0xFFFFFFFE×0x00000003 -> 0x000000000000006A at E3.
- MADD with a zero operand, opdata1_i=0, opdata2_i=7, acc_i=0x10 -> 0x10 at E1.
- RADIX_BITS=4, signed 0x80000000×0x80000000 -> 0x4000000000000000 at E9.
- Unsigned MUL 0xFFFFFFFF×0xFFFFFFFF:
  - annul_i pulsed at E5 -> ready_o stays 0; the next operation 2×3 returns 6 correctly.
  - In a separate run, rst pulled low mid-MulOn -> outputs go to 0 immediately and the FSM is in MulFree.
